// File: rtl/sev_seg_pkg.sv
`default_nettype none
// ============================================================================
// sev_seg_pkg : segment bit positions, hex-to-segment table, polarity helper
// Rev 1.0
// ============================================================================
package sev_seg_pkg;

    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    // Active-high {g,f,e,d,c,b,a} patterns for 0..F (lower-case b and d)
    localparam logic [6:0] HEX_SEG_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic logic [7:0] apply_polarity(input logic [7:0] value,
                                                  input logic       active_low);
        return active_low ? ~value : value;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hex_to_sev_seg.sv
`default_nettype none
// ============================================================================
// hex_to_sev_seg : combinational nibble to active-high 7-segment decoder
// Rev 1.0
// ============================================================================
module hex_to_sev_seg
    import sev_seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = HEX_SEG_TABLE[nibble];

endmodule
`default_nettype wire

// File: rtl/sev_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// sev_seg_scan_ctrl : multiplexed 7-segment scanner, double-buffered, PWM dimmed
// Rev 1.0
// ============================================================================
module sev_seg_scan_ctrl
    import sev_seg_pkg::*;
#(
    parameter int N_DIGITS   = 8,
    parameter int SCAN_DIV   = 15,
    parameter int PWM_BITS   = 3,
    parameter bit ACTIVE_LOW = 1'b1,
    localparam int IDX_W     = $clog2(N_DIGITS)
) (
    input  logic                    clk_slw,
    input  logic                    reset,
    input  logic                    load,
    input  logic [4*N_DIGITS-1:0]   digits,
    input  logic [N_DIGITS-1:0]     dp,
    input  logic [N_DIGITS-1:0]     blank,
    input  logic [PWM_BITS-1:0]     brightness,
    output logic [7:0]              sev_seg_leds,
    output logic [N_DIGITS-1:0]     an,
    output logic [IDX_W-1:0]        digit_idx,
    output logic                    update_pending
);

    localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(N_DIGITS - 1);
    localparam logic [7:0]          SEG_OFF  = ACTIVE_LOW ? 8'hFF : 8'h00;
    localparam logic [N_DIGITS-1:0] AN_OFF   = ACTIVE_LOW ? '1 : '0;

    logic [SCAN_DIV-1:0]   div_cnt;
    logic [IDX_W-1:0]      idx;
    logic                  dwell_end;
    logic                  frame_end;

    logic [4*N_DIGITS-1:0] pend_digits;
    logic [N_DIGITS-1:0]   pend_dp;
    logic [N_DIGITS-1:0]   pend_blank;
    logic [4*N_DIGITS-1:0] act_digits;
    logic [N_DIGITS-1:0]   act_dp;
    logic [N_DIGITS-1:0]   act_blank;

    logic [3:0]            cur_nibble;
    logic [6:0]            cur_seg7;
    logic                  lit;
    logic [7:0]            segs_hi;
    logic [N_DIGITS-1:0]   an_hi;

    assign dwell_end = &div_cnt;
    assign frame_end = dwell_end && (idx == LAST_IDX);

    always_ff @(posedge clk_slw) begin
        if (reset) begin
            div_cnt <= '0;
            idx     <= '0;
        end else begin
            div_cnt <= div_cnt + SCAN_DIV'(1);
            if (dwell_end) begin
                idx <= frame_end ? '0 : idx + IDX_W'(1);
            end
        end
    end

    // Commit reads the pending buffer before a same-edge load overwrites it
    always_ff @(posedge clk_slw) begin
        if (reset) begin
            pend_digits    <= '0;
            pend_dp        <= '0;
            pend_blank     <= '1;
            act_digits     <= '0;
            act_dp         <= '0;
            act_blank      <= '1;
            update_pending <= 1'b0;
        end else begin
            if (load) begin
                pend_digits <= digits;
                pend_dp     <= dp;
                pend_blank  <= blank;
            end
            if (frame_end && update_pending) begin
                act_digits <= pend_digits;
                act_dp     <= pend_dp;
                act_blank  <= pend_blank;
            end
            if (load) begin
                update_pending <= 1'b1;
            end else if (frame_end) begin
                update_pending <= 1'b0;
            end
        end
    end

    assign cur_nibble = act_digits[{idx, 2'b00} +: 4];

    hex_to_sev_seg u_hex_to_sev_seg (
        .nibble (cur_nibble),
        .seg    (cur_seg7)
    );

    // div_cnt==0 is the inter-digit dead cycle that hides anode switching ghosting
    assign lit = !act_blank[idx]
              && (div_cnt != '0)
              && (div_cnt[SCAN_DIV-1 -: PWM_BITS] <= brightness);

    always_comb begin
        segs_hi = 8'h00;
        an_hi   = '0;
        if (lit) begin
            segs_hi[SEG_G:SEG_A] = cur_seg7;
            segs_hi[SEG_DP]      = act_dp[idx];
            an_hi                = N_DIGITS'(1) << idx;
        end
    end

    always_ff @(posedge clk_slw) begin
        if (reset) begin
            sev_seg_leds <= SEG_OFF;
            an           <= AN_OFF;
            digit_idx    <= '0;
        end else begin
            sev_seg_leds <= apply_polarity(segs_hi, ACTIVE_LOW);
            an           <= ACTIVE_LOW ? ~an_hi : an_hi;
            digit_idx    <= idx;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sev_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// tb_sev_seg_scan_ctrl : directed vector bench, 4 digits, 16-cycle dwell, active-low
// Rev 1.0
// ============================================================================
module tb_sev_seg_scan_ctrl;

    localparam int N   = 4;
    localparam int FRM = 64;

    logic        clk_slw = 1'b0;
    logic        reset   = 1'b1;
    logic        load    = 1'b0;
    logic [15:0] digits  = '0;
    logic [3:0]  dp      = '0;
    logic [3:0]  blank   = '0;
    logic [1:0]  brightness = 2'd3;
    logic [7:0]  sev_seg_leds;
    logic [3:0]  an;
    logic [1:0]  digit_idx;
    logic        update_pending;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    sev_seg_scan_ctrl #(
        .N_DIGITS   (N),
        .SCAN_DIV   (4),
        .PWM_BITS   (2),
        .ACTIVE_LOW (1'b1)
    ) dut (
        .clk_slw        (clk_slw),
        .reset          (reset),
        .load           (load),
        .digits         (digits),
        .dp             (dp),
        .blank          (blank),
        .brightness     (brightness),
        .sev_seg_leds   (sev_seg_leds),
        .an             (an),
        .digit_idx      (digit_idx),
        .update_pending (update_pending)
    );

    always #5 clk_slw = ~clk_slw;

    // Posedges since reset release; outputs seen after posedge k show scan phase k-1
    always @(posedge clk_slw) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    typedef struct {
        logic [15:0]      digits;
        logic [3:0]       dp;
        logic [3:0]       blank;
        logic [1:0]       bright;
        logic [3:0][7:0]  leds;
        logic [3:0][3:0]  an;
        logic [3:0][4:0]  lit;
    } vec_t;

    vec_t vecs [4];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(negedge clk_slw);
    endtask

    task automatic step_to(input int target);
        int guard = 0;
        step();
        while ((cyc % FRM) != target) begin
            step();
            guard++;
            if (guard > 2 * FRM) begin
                chk("step_to_timeout", 32'(cyc % FRM), 32'(target));
                return;
            end
        end
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] p,
                           input logic [3:0] b);
        digits = d;
        dp     = p;
        blank  = b;
        load   = 1'b1;
        step();
        load   = 1'b0;
    endtask

    task automatic observe_frame(input int vi);
        int lit [4];
        int p, d, dv;
        for (int i = 0; i < 4; i++) lit[i] = 0;
        for (int c = 0; c < FRM; c++) begin
            step();
            p  = (cyc - 1) % FRM;
            d  = p / 16;
            dv = p % 16;
            chk("digit_idx", 32'(digit_idx), 32'(d));
            if (an != 4'hF) begin
                lit[d]++;
                chk("seg", 32'(sev_seg_leds), 32'(vecs[vi].leds[d]));
                chk("an", 32'(an), 32'(vecs[vi].an[d]));
                chk("dead_cycle_lit", 32'(dv != 0), 32'd1);
            end else begin
                chk("dark_seg", 32'(sev_seg_leds), 32'hFF);
            end
        end
        for (int i = 0; i < 4; i++)
            chk("lit_count", 32'(lit[i]), 32'(vecs[vi].lit[i]));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p;
        vecs[0] = '{16'h8F10, 4'b0000, 4'b0000, 2'd3,
                    {8'h80, 8'h8E, 8'hF9, 8'hC0}, {4'h7, 4'hB, 4'hD, 4'hE},
                    {5'd15, 5'd15, 5'd15, 5'd15}};
        vecs[1] = '{16'hA5C9, 4'b0001, 4'b0100, 2'd0,
                    {8'h88, 8'h92, 8'hC6, 8'h10}, {4'h7, 4'hB, 4'hD, 4'hE},
                    {5'd3, 5'd0, 5'd3, 5'd3}};
        vecs[2] = '{16'h7B2E, 4'b1010, 4'b0000, 2'd1,
                    {8'h78, 8'h83, 8'h24, 8'h86}, {4'h7, 4'hB, 4'hD, 4'hE},
                    {5'd7, 5'd7, 5'd7, 5'd7}};
        vecs[3] = '{16'h6D43, 4'b0000, 4'b1001, 2'd2,
                    {8'h82, 8'hA1, 8'h99, 8'hB0}, {4'h7, 4'hB, 4'hD, 4'hE},
                    {5'd0, 5'd11, 5'd11, 5'd0}};

        // Reset hold and a full idle frame
        repeat (3) step();
        chk("rst_seg", 32'(sev_seg_leds), 32'hFF);
        chk("rst_an", 32'(an), 32'hF);
        chk("rst_pending", 32'(update_pending), 32'd0);
        chk("rst_idx", 32'(digit_idx), 32'd0);
        reset = 1'b0;
        for (int c = 0; c < FRM; c++) begin
            step();
            p = (cyc - 1) % FRM;
            chk("idle_seg", 32'(sev_seg_leds), 32'hFF);
            chk("idle_an", 32'(an), 32'hF);
            chk("idle_pending", 32'(update_pending), 32'd0);
            chk("idle_idx", 32'(digit_idx), 32'(p / 16));
        end

        // Table-driven frames: load, commit, observe one full frame
        for (int v = 0; v < 4; v++) begin
            brightness = vecs[v].bright;
            do_load(vecs[v].digits, vecs[v].dp, vecs[v].blank);
            chk("pending_rise", 32'(update_pending), 32'd1);
            if ((cyc % FRM) != 0) step_to(0);
            chk("pending_fall", 32'(update_pending), 32'd0);
            observe_frame(v);
        end

        // Tear-free: new data loaded while idx=1 must wait for the frame boundary
        brightness = 2'd3;
        do_load(16'h8F10, 4'b0000, 4'b0000);
        step_to(0);
        step_to(20);
        do_load(16'h1234, 4'b0000, 4'b0000);
        while ((cyc % FRM) != 0) begin
            chk("tf_pending_high", 32'(update_pending), 32'd1);
            if ((cyc % FRM) == 38) chk("tf_old_d2", 32'(sev_seg_leds), 32'h8E);
            if ((cyc % FRM) == 54) chk("tf_old_d3", 32'(sev_seg_leds), 32'h80);
            step();
        end
        chk("tf_pending_low", 32'(update_pending), 32'd0);
        step_to(1);
        chk("tf_new_d0_dead", 32'(an), 32'hF);
        step();
        chk("tf_new_d0_seg", 32'(sev_seg_leds), 32'h99);
        chk("tf_new_d0_an", 32'(an), 32'hE);
        step_to(18);
        chk("tf_new_d1_seg", 32'(sev_seg_leds), 32'hB0);
        chk("tf_new_d1_an", 32'(an), 32'hD);

        // Load exactly on the commit edge
        step_to(30);
        do_load(16'h5555, 4'b0000, 4'b0000);
        step_to(63);
        digits = 16'hEEEE;
        load   = 1'b1;
        step();
        load   = 1'b0;
        chk("ce_pending_kept", 32'(update_pending), 32'd1);
        step_to(2);
        chk("ce_old_pend_seg", 32'(sev_seg_leds), 32'h92);
        chk("ce_old_pend_an", 32'(an), 32'hE);
        step_to(63);
        chk("ce_pending_frame", 32'(update_pending), 32'd1);
        step();
        chk("ce_pending_clear", 32'(update_pending), 32'd0);
        step_to(2);
        chk("ce_new_seg", 32'(sev_seg_leds), 32'h86);

        // Reset mid-frame with pending data; load during reset is ignored
        step_to(40);
        do_load(16'h0000, 4'b0000, 4'b0000);
        chk("mr_pending_set", 32'(update_pending), 32'd1);
        step_to(42);
        reset = 1'b1;
        load  = 1'b1;
        step();
        chk("mr_seg", 32'(sev_seg_leds), 32'hFF);
        chk("mr_an", 32'(an), 32'hF);
        chk("mr_pending", 32'(update_pending), 32'd0);
        chk("mr_idx", 32'(digit_idx), 32'd0);
        step();
        reset = 1'b0;
        load  = 1'b0;
        step();
        chk("mr_load_ignored", 32'(update_pending), 32'd0);
        step();
        chk("mr_dark_after", 32'(sev_seg_leds), 32'hFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sev_seg_scan_ctrl.md
# sev_seg_scan_ctrl

Parametrised multiplexed seven-segment display controller for the 4-bit add/sub board. It takes N_DIGITS packed hex nibbles plus per-digit decimal-point and blank masks, and scans them onto a shared segment bus with one anode per digit. It adds tear-free double-buffered updates, PWM brightness and an inter-digit dead cycle. It runs in the clk_slw domain and replaces the fixed two-digit driver in the display top level.

## Interface
Parameters:
- N_DIGITS, 8, number of digits/anodes (2..8)
- SCAN_DIV, 15, dwell per digit = 2^SCAN_DIV clk_slw cycles (SCAN_DIV > PWM_BITS)
- PWM_BITS, 3, brightness resolution
- ACTIVE_LOW, 1, 1 = segments and anodes driven active-low

Ports:
- clk_slw  in  1  scan clock
- reset  in  1  synchronous, active-high; clock clk_slw
- load  in  1  one-cycle strobe: capture digits/dp/blank into pending buffer
- digits  in  4*N_DIGITS  hex nibbles; digit 0 = bits [3:0]
- dp  in  N_DIGITS  decimal point enable per digit
- blank  in  N_DIGITS  1 = digit dark
- brightness  in  PWM_BITS  duty select; all-ones = maximum
- sev_seg_leds  out  8  {dp,g,f,e,d,c,b,a}
- an  out  N_DIGITS  anode drive, one-hot active (polarity per ACTIVE_LOW)
- digit_idx  out  $clog2(N_DIGITS)  index of digit currently on the segment bus
- update_pending  out  1  pending buffer holds data not yet committed

## Operation
- Dwell counter div_cnt (SCAN_DIV bits) increments every cycle. When div_cnt is all-ones, idx advances; N_DIGITS-1 wraps to 0.
- Pending buffer: load=1 copies digits/dp/blank into it and sets update_pending.
- Commit (frame boundary): on the edge where idx==N_DIGITS-1 and div_cnt is all-ones, the active buffer takes the pending buffer if update_pending=1, and update_pending clears.
- Load on the commit edge: the commit uses the old pending contents; the new data enters pending; update_pending stays 1.
- Digit lit = !blank[idx] && div_cnt!=0 (dead cycle) && div_cnt[SCAN_DIV-1 -: PWM_BITS] <= brightness.
- Lit digit: an has only bit idx active; segments = hex decode of nibble idx, with dp bit from dp[idx].
- Unlit digit: all anodes inactive; segments all off.
- Hex decode, active-high g..a: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71. ACTIVE_LOW inverts all 8 segment bits and all anodes.
- Reset values: div_cnt=0, idx=0, active and pending buffers digits=0/dp=0/blank=all-ones, update_pending=0.
- Outputs after reset: sev_seg_leds=all off (8'hFF when ACTIVE_LOW), an=all inactive, digit_idx=0.

## Timing
- All outputs are registered. The outputs after edge t+1 reflect idx, div_cnt and active buffer state as of edge t: 1-cycle latency.
- update_pending rises on the edge after load and falls on the commit edge.
- First frame showing new data begins with digit 0, the cycle after the commit edge plus the 1-cycle output latency.
- Reset asserted mid-frame: every register returns to its reset value on that edge. load is ignored while reset=1.
- Frame period = N_DIGITS * 2^SCAN_DIV cycles. Lit cycles per dwell = (brightness+1)*2^(SCAN_DIV-PWM_BITS) - 1.

## Structure
- Package sev_seg_pkg holds:
  - segment bit-position constants (SEG_A..SEG_DP)
  - the 16-entry hex-to-segment constant table
  - a function applying ACTIVE_LOW polarity
- Sub-module hex_to_sev_seg: combinational nibble-to-7-segment decoder, instantiated once on the muxed nibble.
- The top level holds the counters, both buffers, commit logic, PWM compare and output registers.

## Test plan
Bench parameters: N_DIGITS=4, SCAN_DIV=4, PWM_BITS=2, ACTIVE_LOW=1.
- Reset check: hold reset 3 cycles, then release with no load -> sev_seg_leds=8'hFF, an=4'hF, update_pending=0, digit_idx=0 for a full 64-cycle frame.
- Scan and decode: load digits=16'h8F10, dp=0, blank=0, brightness=3 -> after commit:
  - digit 0 shows sev_seg_leds=8'hC0 with an=4'hE
  - digit 1 shows 8'hF9 with an=4'hD
  - digit 2 shows 8'h8E with an=4'hB
  - digit 3 shows 8'h80 with an=4'h7
  - each digit lit 15 of 16 cycles, with the dead cycle at div_cnt=0
- Tear-free update: load new digits mid-frame at idx=1 -> active digits unchanged until the commit edge; update_pending high until that edge; the next digit 0 shows the new value.
- Load on commit edge: load on the exact commit edge -> the old pending contents are displayed and update_pending remains 1 for one more frame.
- Brightness and masks: brightness=0 -> each digit lit exactly 3 cycles per 16-cycle dwell. blank=4'b0100 -> an never 4'hB. dp=4'b0001 -> digit 0 sev_seg_leds bit7=0.
- Reset mid-operation: assert reset at idx=2 with update_pending=1 -> next edge: all outputs off, update_pending=0, digit_idx=0.
